pong_paddle_ctrl: RTL and testbench
===================================

Name: pong_paddle_ctrl

Overview:
- Player-side producer of the paddle-position interface consumed by the ball controller (i_Paddle_Pos_Left / i_Paddle_Pos_Right). One instance per player.
- Debounces raw up/down buttons, steps the paddle one cell at a fixed rate while a button is held, and clamps the paddle to the play field.
- Recentres the paddle on a serve request and produces the registered paddle pixel-draw strobe for the VGA mux.

Parameters:
- HMAX, 800, horizontal total count; sets the i_H_count width.
- VMAX, 525, vertical total count; sets the i_V_count width.
- HEIGHT, 30, play-field height in cells; sets the o_Paddle_Pos width.
- PIXEL_SIZE, 16, pixels per cell edge.
- PADDLE_COL, 5, paddle column in cells (use 5 for left, 36 for right).
- PADDLE_HALF, 3, paddle extends ±PADDLE_HALF cells from its centre.
- TOP_POS_MIN, 1, top field row.
- BOT_POS_MAX, 30, bottom field row.
- PAD_INIT, 15, centre row after reset or recentre.
- DEBOUNCE, 250000, stable cycles required to accept a button level.
- MOVE_SPEED, 1250000, cycles between steps while a button is held.

Ports:
- i_Clk  in  1  system/pixel clock.
- i_Reset_n  in  1  asynchronous active-low reset.
- i_Up  in  1  raw up button (asynchronous, bouncy).
- i_Down  in  1  raw down button (asynchronous, bouncy).
- i_Enable  in  1  movement allowed (game in play).
- i_Recenter  in  1  single-cycle pulse: return paddle to PAD_INIT.
- i_H_count  in  $clog2(HMAX)  current pixel column.
- i_V_count  in  $clog2(VMAX)  current pixel row.
- o_Paddle_Pos  out  $clog2(HEIGHT)  paddle centre row.
- o_Draw_Paddle  out  1  current pixel lies on the paddle.

Behaviour:
- Reset (async assert, sync release): o_Paddle_Pos=PAD_INIT, o_Draw_Paddle=0, all counters 0, debounced levels 0, FSM=IDLE.
- Input sync: each button passes through a 2-flop synchroniser.
- Debounce (one instance per button):
  - The counter resets whenever the synchronised level equals the accepted level.
  - Otherwise it increments; when it reaches DEBOUNCE-1 the accepted level flips and the counter clears.
  - Latency from a clean edge to the accepted level = 2 + DEBOUNCE cycles.
- Direction: dir = UP when up=1 & down=0; DOWN when down=1 & up=0; NONE otherwise (both pressed counts as NONE).
- Limits: POS_MIN = TOP_POS_MIN+PADDLE_HALF (4), POS_MAX = BOT_POS_MAX-PADDLE_HALF (27).
- FSM states:
  - IDLE: if i_Enable and dir≠NONE, go to STEP.
  - STEP: apply one step, clear the rate counter, go to HOLD. Step rules:
    - UP: pos-1 if pos>POS_MIN, else hold.
    - DOWN: pos+1 if pos<POS_MAX, else hold.
  - HOLD: if dir=NONE or !i_Enable, go to IDLE. Otherwise increment the rate counter; at MOVE_SPEED-1, go to STEP.
- Step timing: the first step lands 1 cycle after entering STEP from a press. Subsequent steps are spaced exactly MOVE_SPEED+1 cycles apart.
- Direction change during HOLD: the rate count continues; the next STEP uses the current dir.
- Recenter priority: i_Recenter overrides everything in the same cycle: pos=PAD_INIT, rate counter=0, FSM=IDLE. Debouncers are unaffected. A button still held resumes stepping on the next IDLE evaluation, if enabled.
- Clamping: o_Paddle_Pos never leaves [POS_MIN, POS_MAX]; no wrap-around.
- Draw strobe: registered, 1-cycle latency. It is 1 iff all of the following hold:
  - i_H_count > (PADDLE_COL-1)*PIXEL_SIZE
  - i_H_count < PADDLE_COL*PIXEL_SIZE
  - i_V_count > (pos-PADDLE_HALF-1)*PIXEL_SIZE
  - i_V_count < (pos+PADDLE_HALF)*PIXEL_SIZE
- Arithmetic: compute all pixel arithmetic at i_H_count/i_V_count width plus 1 bit; no truncation of products.
- o_Paddle_Pos is a registered output and changes only on STEP, recentre, or reset.

Decomposition:
- Shared package pong_pkg holds the field constants HEIGHT, WIDTH, PIXEL_SIZE, TOP_POS_MIN, BOT_POS_MAX, PAD_INIT, PADDLE_HALF, and the FSM state localparams (IDLE, STEP, HOLD). The ball controller uses the same PADDLE_HALF so that its collision window of ±(PADDLE_HALF+1) stays consistent.
- One sub-module: pong_debounce (synchroniser + counter, parameter DEBOUNCE), instantiated twice.

Test Plan:
(All scenarios use DEBOUNCE=4, MOVE_SPEED=8.)
- Reset: release i_Reset_n -> o_Paddle_Pos=15 and o_Draw_Paddle=0. Assert reset mid-HOLD -> pos returns to 15 immediately (asynchronous).
- Bounce rejection and single step: toggle i_Up every 2 cycles for 20 cycles with i_Enable=1 -> pos stays 15. Then hold i_Up stable -> pos=14 exactly 2+4+2 cycles after the last edge, and 13 after 9 more cycles.
- Clamp: hold i_Down for 200 cycles -> pos rises to 27 and stays there. Hold i_Up -> pos bottoms out at 4 and never reaches 3.
- Both buttons / disable: press both -> pos unchanged. Drop i_Enable during HOLD -> FSM returns to IDLE and no further steps occur.
- Recenter priority: pos=20 with i_Down held, pulse i_Recenter on the cycle a STEP would occur -> pos=15 (not 21), then stepping resumes.
- Draw window: pos=15, PADDLE_COL=5 -> o_Draw_Paddle=1 for (H=70, V=200) and 0 for (H=80, V=200) and (H=70, V=176). Each result appears 1 cycle after the count is applied.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared play-field constants and paddle controller types.
// The ball controller pulls PADDLE_HALF from here as well, so its
// +/-(PADDLE_HALF+1) collision window always tracks the drawn paddle.
package pong_pkg;

  localparam int unsigned HMAX        = 800;
  localparam int unsigned VMAX        = 525;
  localparam int unsigned HEIGHT      = 30;
  localparam int unsigned WIDTH       = 40;
  localparam int unsigned PIXEL_SIZE  = 16;
  localparam int unsigned TOP_POS_MIN = 1;
  localparam int unsigned BOT_POS_MAX = 30;
  localparam int unsigned PAD_INIT    = 15;
  localparam int unsigned PADDLE_HALF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    HOLD = 2'd2
  } paddle_state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } paddle_dir_e;

  // Pressing both buttons cancels out.
  function automatic paddle_dir_e dir_decode(input logic up, input logic down);
    paddle_dir_e d;
    d = DIR_NONE;
    if (up && !down) d = DIR_UP;
    else if (down && !up) d = DIR_DOWN;
    return d;
  endfunction

endpackage

// File: rtl/pong_paddle_ctrl_if.sv
// Player-side paddle bus: buttons, game control and raster position in,
// paddle centre row and pixel-draw strobe out.
//   master : the paddle controller (drives o_Paddle_Pos / o_Draw_Paddle)
//   slave  : the game / VGA side that feeds buttons and raster counts
interface pong_paddle_ctrl_if #(
  parameter int unsigned HMAX   = pong_pkg::HMAX,
  parameter int unsigned VMAX   = pong_pkg::VMAX,
  parameter int unsigned HEIGHT = pong_pkg::HEIGHT
);

  localparam int unsigned H_W = $clog2(HMAX);
  localparam int unsigned V_W = $clog2(VMAX);
  localparam int unsigned P_W = $clog2(HEIGHT);

  logic           i_Up;
  logic           i_Down;
  logic           i_Enable;
  logic           i_Recenter;
  logic [H_W-1:0] i_H_count;
  logic [V_W-1:0] i_V_count;
  logic [P_W-1:0] o_Paddle_Pos;
  logic           o_Draw_Paddle;

  modport master (
    input  i_Up, i_Down, i_Enable, i_Recenter, i_H_count, i_V_count,
    output o_Paddle_Pos, o_Draw_Paddle
  );

  modport slave (
    output i_Up, i_Down, i_Enable, i_Recenter, i_H_count, i_V_count,
    input  o_Paddle_Pos, o_Draw_Paddle
  );

endinterface

// File: rtl/pong_debounce.sv
// Button conditioner: 2-flop synchroniser followed by a stability counter.
// The accepted level flips only after the synchronised input has disagreed
// with it for DEBOUNCE consecutive cycles (edge-to-level latency 2+DEBOUNCE).
//   i_Clk, i_Reset_n : clock, async active-low reset
//   i_Raw            : raw asynchronous button
//   o_Level          : registered debounced level
module pong_debounce #(
  parameter int unsigned DEBOUNCE = 250000
) (
  input  logic i_Clk,
  input  logic i_Reset_n,
  input  logic i_Raw,
  output logic o_Level
);

  localparam int unsigned C_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [C_W-1:0] CNT_LAST = C_W'(DEBOUNCE - 1);

  logic           sync_q1;
  logic           sync_q2;
  logic [C_W-1:0] cnt_q;

  // Metastability guard.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= i_Raw;
      sync_q2 <= sync_q1;
    end
  end

  // Any agreement with the accepted level restarts the stability count.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      cnt_q   <= '0;
      o_Level <= 1'b0;
    end else if (sync_q2 == o_Level) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q   <= '0;
      o_Level <= ~o_Level;
    end else begin
      cnt_q <= cnt_q + C_W'(1);
    end
  end

endmodule

// File: rtl/pong_paddle_ctrl.sv
// Paddle controller: debounces the up/down buttons, steps the paddle one
// cell per MOVE_SPEED+1 cycles while a direction is held, clamps it inside
// the field, recentres on request and raises the registered draw strobe.
//   i_Clk, i_Reset_n : clock, async active-low reset
//   bus (master)     : buttons, enable, recentre, raster counts in;
//                      o_Paddle_Pos (centre row), o_Draw_Paddle out
module pong_paddle_ctrl #(
  parameter int unsigned HMAX        = pong_pkg::HMAX,
  parameter int unsigned VMAX        = pong_pkg::VMAX,
  parameter int unsigned HEIGHT      = pong_pkg::HEIGHT,
  parameter int unsigned PIXEL_SIZE  = pong_pkg::PIXEL_SIZE,
  parameter int unsigned PADDLE_COL  = 5,
  parameter int unsigned PADDLE_HALF = pong_pkg::PADDLE_HALF,
  parameter int unsigned TOP_POS_MIN = pong_pkg::TOP_POS_MIN,
  parameter int unsigned BOT_POS_MAX = pong_pkg::BOT_POS_MAX,
  parameter int unsigned PAD_INIT    = pong_pkg::PAD_INIT,
  parameter int unsigned DEBOUNCE    = 250000,
  parameter int unsigned MOVE_SPEED  = 1250000
) (
  input  logic               i_Clk,
  input  logic               i_Reset_n,
  pong_paddle_ctrl_if.master bus
);

  import pong_pkg::*;

  localparam int unsigned H_W     = $clog2(HMAX);
  localparam int unsigned V_W     = $clog2(VMAX);
  localparam int unsigned P_W     = $clog2(HEIGHT);
  localparam int unsigned HX_W    = H_W + 1;
  localparam int unsigned VX_W    = V_W + 1;
  localparam int unsigned R_W     = (MOVE_SPEED > 1) ? $clog2(MOVE_SPEED) : 1;
  localparam int unsigned POS_MIN = TOP_POS_MIN + PADDLE_HALF;
  localparam int unsigned POS_MAX = BOT_POS_MAX - PADDLE_HALF;

  localparam logic [HX_W-1:0] H_LO      = HX_W'((PADDLE_COL - 1) * PIXEL_SIZE);
  localparam logic [HX_W-1:0] H_HI      = HX_W'(PADDLE_COL * PIXEL_SIZE);
  localparam logic [R_W-1:0]  RATE_LAST = R_W'(MOVE_SPEED - 1);

  // Elaboration guard: the paddle column must sit inside the play field.
  if (PADDLE_COL == 0 || PADDLE_COL > WIDTH) begin : g_bad_col
    $error("PADDLE_COL outside play field");
  end

  logic            up_lvl;
  logic            down_lvl;
  paddle_dir_e     dir;
  paddle_state_e   state_q, state_d;
  logic [P_W-1:0]  pos_q, pos_d;
  logic [R_W-1:0]  rate_q, rate_d;
  logic            draw_q, draw_d;
  logic [HX_W-1:0] h_ext;
  logic [VX_W-1:0] v_ext, pos_ext, v_lo, v_hi;

  pong_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_up (
    .i_Clk     (i_Clk),
    .i_Reset_n (i_Reset_n),
    .i_Raw     (bus.i_Up),
    .o_Level   (up_lvl)
  );

  pong_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_down (
    .i_Clk     (i_Clk),
    .i_Reset_n (i_Reset_n),
    .i_Raw     (bus.i_Down),
    .o_Level   (down_lvl)
  );

  assign dir = dir_decode(up_lvl, down_lvl);

  // State, position, rate counter and draw strobe registers.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q <= IDLE;
      pos_q   <= P_W'(PAD_INIT);
      rate_q  <= '0;
      draw_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      rate_q  <= rate_d;
      draw_q  <= draw_d;
    end
  end

  // Movement sequencing; recentre wins over any step in the same cycle.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    rate_d  = rate_q;
    if (bus.i_Recenter) begin
      state_d = IDLE;
      pos_d   = P_W'(PAD_INIT);
      rate_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_Enable && dir != DIR_NONE) state_d = STEP;
        end
        STEP: begin
          if (dir == DIR_UP && pos_q > P_W'(POS_MIN)) begin
            pos_d = pos_q - P_W'(1);
          end else if (dir == DIR_DOWN && pos_q < P_W'(POS_MAX)) begin
            pos_d = pos_q + P_W'(1);
          end
          rate_d  = '0;
          state_d = HOLD;
        end
        HOLD: begin
          if (dir == DIR_NONE || !bus.i_Enable) begin
            state_d = IDLE;
          end else if (rate_q == RATE_LAST) begin
            state_d = STEP;
          end else begin
            rate_d = rate_q + R_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Draw window, evaluated one bit wider than the raster counts.
  always_comb begin
    h_ext   = HX_W'(bus.i_H_count);
    v_ext   = VX_W'(bus.i_V_count);
    pos_ext = VX_W'(pos_q);
    v_lo    = (pos_ext - VX_W'(PADDLE_HALF + 1)) * VX_W'(PIXEL_SIZE);
    v_hi    = (pos_ext + VX_W'(PADDLE_HALF)) * VX_W'(PIXEL_SIZE);
    draw_d  = (h_ext > H_LO) && (h_ext < H_HI) && (v_ext > v_lo) && (v_ext < v_hi);
  end

  assign bus.o_Paddle_Pos  = pos_q;
  assign bus.o_Draw_Paddle = draw_q;

endmodule

// File: tb/tb_pong_paddle_ctrl.sv
// Bench for pong_paddle_ctrl with DEBOUNCE=4, MOVE_SPEED=8, PADDLE_COL=5.
// A cycle-level model (stable-sample window for the buttons, step countdown
// for movement, integer window for drawing) is checked on every falling
// edge; directed literal checks pin the model's key timings and values.
module tb_pong_paddle_ctrl;

  localparam int DB     = 4;
  localparam int MS     = 8;
  localparam int COL    = 5;
  localparam int PIX    = 16;
  localparam int HALF   = 3;
  localparam int P_MIN  = 4;
  localparam int P_MAX  = 27;
  localparam int P_INIT = 15;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  pong_paddle_ctrl_if bus ();

  pong_paddle_ctrl #(
    .DEBOUNCE   (DB),
    .MOVE_SPEED (MS),
    .PADDLE_COL (COL)
  ) dut (
    .i_Clk     (clk),
    .i_Reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Model state
  int m_pos;
  bit m_moving;
  int m_until;
  bit m_draw;
  bit m_lvl  [2];
  bit m_hist [2][DB+2];

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pos    = P_INIT;
    m_moving = 1'b0;
    m_until  = 0;
    m_draw   = 1'b0;
    for (int b = 0; b < 2; b++) begin
      m_lvl[b] = 1'b0;
      for (int k = 0; k < DB + 2; k++) m_hist[b][k] = 1'b0;
    end
  endfunction

  // Level flips once the samples taken 2..DB+1 edges ago all disagree with it.
  function automatic void model_button(input int b, input bit raw);
    bit all_diff;
    for (int k = DB + 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
    m_hist[b][0] = raw;
    all_diff = 1'b1;
    for (int k = 2; k <= DB + 1; k++) if (m_hist[b][k] == m_lvl[b]) all_diff = 1'b0;
    if (all_diff) m_lvl[b] = ~m_lvl[b];
  endfunction

  // Advance the model across the coming rising edge using the present inputs.
  function automatic void model_step();
    int h;
    int v;
    int dir;
    h = int'(bus.i_H_count);
    v = int'(bus.i_V_count);
    m_draw = (h > (COL - 1) * PIX) && (h < COL * PIX) &&
             (v > (m_pos - HALF - 1) * PIX) && (v < (m_pos + HALF) * PIX);
    dir = (m_lvl[0] && !m_lvl[1]) ? 1 : ((m_lvl[1] && !m_lvl[0]) ? 2 : 0);
    if (bus.i_Recenter) begin
      m_pos    = P_INIT;
      m_moving = 1'b0;
    end else if (!m_moving) begin
      if (bus.i_Enable && dir != 0) begin
        m_moving = 1'b1;
        m_until  = 1;
      end
    end else if (m_until == 1) begin
      if (dir == 1 && m_pos > P_MIN) m_pos = m_pos - 1;
      else if (dir == 2 && m_pos < P_MAX) m_pos = m_pos + 1;
      m_until = MS + 1;
    end else if (dir == 0 || !bus.i_Enable) begin
      m_moving = 1'b0;
    end else begin
      m_until = m_until - 1;
    end
    model_button(0, bus.i_Up);
    model_button(1, bus.i_Down);
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
      check("reset_pos", int'(bus.o_Paddle_Pos), P_INIT);
      check("reset_draw", int'(bus.o_Draw_Paddle), 0);
    end else begin
      check("model_pos", int'(bus.o_Paddle_Pos), m_pos);
      check("model_draw", int'(bus.o_Draw_Paddle), int'(m_draw));
      model_step();
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int dv_h   [10] = '{70, 80, 70, 70, 70, 70, 65, 64, 79, 0};
  int dv_v   [10] = '{200, 200, 176, 177, 287, 288, 200, 200, 200, 0};
  int dv_exp [10] = '{1, 0, 0, 1, 1, 0, 1, 0, 1, 0};

  initial begin
    int n;
    int prev;
    rst_n          = 1'b1;
    bus.i_Up       = 1'b0;
    bus.i_Down     = 1'b0;
    bus.i_Enable   = 1'b0;
    bus.i_Recenter = 1'b0;
    bus.i_H_count  = '0;
    bus.i_V_count  = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("release_pos", int'(bus.o_Paddle_Pos), 15);
    check("release_draw", int'(bus.o_Draw_Paddle), 0);

    // Bouncy up button, then a clean press
    bus.i_Enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.i_Up = (i % 2 == 0);
      tick(2);
    end
    check("bounce_reject", int'(bus.o_Paddle_Pos), 15);
    bus.i_Up = 1'b1;
    tick(7);
    check("first_step_early", int'(bus.o_Paddle_Pos), 15);
    tick(1);
    check("first_step", int'(bus.o_Paddle_Pos), 14);
    tick(8);
    check("second_step_early", int'(bus.o_Paddle_Pos), 14);
    tick(1);
    check("second_step", int'(bus.o_Paddle_Pos), 13);
    bus.i_Up = 1'b0;
    tick(12);
    check("release_stops", int'(bus.o_Paddle_Pos), 13);

    // Clamps at both ends
    bus.i_Down = 1'b1;
    tick(200);
    check("clamp_max", int'(bus.o_Paddle_Pos), 27);
    bus.i_Down = 1'b0;
    bus.i_Up   = 1'b1;
    tick(300);
    check("clamp_min", int'(bus.o_Paddle_Pos), 4);
    bus.i_Up = 1'b0;
    tick(20);

    // Disable during HOLD
    bus.i_Down = 1'b1;
    tick(10);
    check("disable_first_step", int'(bus.o_Paddle_Pos), 5);
    bus.i_Enable = 1'b0;
    tick(40);
    check("disable_holds", int'(bus.o_Paddle_Pos), 5);

    // Both buttons pressed together
    bus.i_Down = 1'b0;
    tick(20);
    bus.i_Enable = 1'b1;
    bus.i_Up     = 1'b1;
    bus.i_Down   = 1'b1;
    tick(60);
    check("both_pressed", int'(bus.o_Paddle_Pos), 5);

    // Recentre on the cycle a step would land
    bus.i_Up = 1'b0;
    n = 0;
    while (int'(bus.o_Paddle_Pos) != 20 && n < 400) begin
      tick(1);
      n++;
    end
    check("reach_20", int'(bus.o_Paddle_Pos), 20);
    tick(8);
    check("pre_recenter", int'(bus.o_Paddle_Pos), 20);
    bus.i_Recenter = 1'b1;
    tick(1);
    bus.i_Recenter = 1'b0;
    check("recenter", int'(bus.o_Paddle_Pos), 15);
    tick(2);
    check("resume_after_recenter", int'(bus.o_Paddle_Pos), 16);

    // Asynchronous reset mid-HOLD
    tick(3);
    #1 rst_n = 1'b0;
    bus.i_Down = 1'b0;
    #1;
    check("async_reset_pos", int'(bus.o_Paddle_Pos), 15);
    check("async_reset_draw", int'(bus.o_Draw_Paddle), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(2);

    // Draw window at pos 15, one-cycle latency
    prev = 0;
    for (int i = 0; i < 10; i++) begin
      bus.i_H_count = 10'(dv_h[i]);
      bus.i_V_count = 10'(dv_v[i]);
      #1;
      check("draw_latency", int'(bus.o_Draw_Paddle), prev);
      tick(1);
      check("draw_window", int'(bus.o_Draw_Paddle), dv_exp[i]);
      prev = dv_exp[i];
    end

    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
